// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the ARM pipeline. This block owns the program
// counter and drives the word-indexed instruction memory. Each returned
// instruction is captured together with its pc+4 into a 2-entry FIFO (skid
// buffer). The head of that FIFO is presented to decode through a valid/ready
// handshake. A branch redirect from downstream flushes the buffer and reloads
// the PC. The memory read strobe is suppressed in the cycle of the redirect.
//
// Parameters:
//   INSTR_W   instruction / memory data width
//   ADDR_W    PC and memory address width
//   RESET_PC  byte address loaded on reset (word aligned)
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   branch_taken  one-cycle redirect request
//   branch_addr   redirect byte address (low two bits ignored)
//   mem_addr      word index into instruction memory ({2'b0, pc[ADDR_W-1:2]})
//   mem_read      fetch strobe (combinational)
//   mem_data      memory read data, valid in the same cycle as mem_read
//   id_ready      decode accepts the head instruction this cycle
//   valid_out     head-of-buffer entry is valid
//   instr_out     head instruction (0 when not valid)
//   pc_out        head instruction byte address + 4 (0 when not valid)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned             INSTR_W  = 32,
    parameter int unsigned             ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_addr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_read,
    input  logic [INSTR_W-1:0]  mem_data,
    input  logic                id_ready,
    output logic                valid_out,
    output logic [INSTR_W-1:0]  instr_out,
    output logic [ADDR_W-1:0]   pc_out
);

    // Architectural state: PC, two FIFO slots, occupancy and 1-bit pointers.
    logic [ADDR_W-1:0]  pc_q,        pc_d;
    logic [INSTR_W-1:0] instr_q [2];
    logic [INSTR_W-1:0] instr_d [2];
    logic [ADDR_W-1:0]  pc4_q   [2];
    logic [ADDR_W-1:0]  pc4_d   [2];
    logic [1:0]         count_q,     count_d;
    logic               rd_ptr_q,    rd_ptr_d;
    logic               wr_ptr_q,    wr_ptr_d;

    logic [ADDR_W-1:0]  pc_plus4;
    logic               pop;
    logic               can_fetch;

    // Handshake and fetch-enable logic. A pop in the same cycle frees a slot,
    // so a full buffer can still fetch when decode is draining it.
    always_comb begin
        pc_plus4  = pc_q + ADDR_W'(4);
        valid_out = (count_q != 2'd0);
        pop       = valid_out & id_ready;
        can_fetch = (count_q < 2'd2) | pop;
        mem_read  = ~rst & ~branch_taken & can_fetch;
        mem_addr  = {2'b00, pc_q[ADDR_W-1:2]};
    end

    // Head-of-buffer outputs come straight from registered FIFO state and are
    // forced to zero while the buffer is empty.
    always_comb begin
        instr_out = '0;
        pc_out    = '0;
        if (valid_out) begin
            instr_out = instr_q[rd_ptr_q];
            pc_out    = pc4_q[rd_ptr_q];
        end
    end

    // Next-state logic. A redirect wins over any push or pop in the same
    // cycle: the buffer is emptied and the PC reloaded with the aligned target.
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;

        if (branch_taken) begin
            pc_d     = branch_addr & ~ADDR_W'(3);
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (mem_read) begin
                instr_d[wr_ptr_q] = mem_data;
                pc4_d[wr_ptr_q]   = pc_plus4;
                wr_ptr_d          = ~wr_ptr_q;
                pc_d              = pc_plus4;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({mem_read, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers. Reset is synchronous and overrides a redirect. The
    // data slots need no reset because count gates their visibility.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
        instr_q <= instr_d;
        pc4_q   <= pc4_d;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Testbench for fetch_stage. A combinational instruction memory returns a
// simple arithmetic pattern for every word index. A queue-based reference
// model tracks which instructions decode should see. A negedge compare
// process checks every DUT output against that model on every cycle. Directed
// sequences add literal, hand-computed checks at key points.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int unsigned      INSTR_W  = 32;
    localparam int unsigned      ADDR_W   = 32;
    localparam logic [31:0]      RESET_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic [31:0] mem_data;
    logic        id_ready;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    int tests_run    = 0;
    int tests_failed = 0;

    fetch_stage #(
        .INSTR_W  (INSTR_W),
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_data     (mem_data),
        .id_ready     (id_ready),
        .valid_out    (valid_out),
        .instr_out    (instr_out),
        .pc_out       (pc_out)
    );

    // Memory contents: word k = 0x00221000 + k*0x00420000 (mod 2^32).
    function automatic logic [31:0] mem_word(input logic [31:0] idx);
        return 32'h0022_1000 + idx * 32'h0042_0000;
    endfunction

    assign mem_data = mem_word(mem_addr);

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instructions owed to decode, in order, plus the
    // byte PC of the next fetch.
    logic [31:0] mq_instr [$];
    logic [31:0] mq_pc4   [$];
    logic [31:0] m_pc     = RESET_PC;
    bit          m_synced = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq_instr.delete();
            mq_pc4.delete();
            m_pc     = RESET_PC;
            m_synced = 1'b1;
        end else if (branch_taken) begin
            mq_instr.delete();
            mq_pc4.delete();
            m_pc = {branch_addr[31:2], 2'b00};
        end else begin
            bit took;
            took = (mq_instr.size() > 0) && id_ready;
            if (took) begin
                void'(mq_instr.pop_front());
                void'(mq_pc4.pop_front());
            end
            if (mq_instr.size() < 2) begin
                mq_instr.push_back(mem_word(m_pc >> 2));
                mq_pc4.push_back(m_pc + 32'd4);
                m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_synced) begin
            bit          e_valid;
            logic [31:0] e_instr;
            logic [31:0] e_pc4;
            bit          e_read;
            e_valid = mq_instr.size() > 0;
            e_instr = e_valid ? mq_instr[0] : 32'h0;
            e_pc4   = e_valid ? mq_pc4[0]   : 32'h0;
            e_read  = !rst && !branch_taken &&
                      ((mq_instr.size() < 2) || (e_valid && id_ready));
            checkOutput("model valid_out", {31'b0, valid_out}, {31'b0, e_valid});
            checkOutput("model instr_out", instr_out, e_instr);
            checkOutput("model pc_out",    pc_out,    e_pc4);
            checkOutput("model mem_read",  {31'b0, mem_read}, {31'b0, e_read});
            checkOutput("model mem_addr",  mem_addr,  m_pc >> 2);
        end
    end

    // Drive one cycle of inputs, let the rising edge consume them, and return
    // just after the edge.
    task automatic applyStimulus(input logic r, input logic b,
                                 input logic [31:0] a, input logic rdy);
        rst          = r;
        branch_taken = b;
        branch_addr  = a;
        id_ready     = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkHead(input string name, input logic v,
                             input logic [31:0] ins, input logic [31:0] p4);
        checkOutput({name, " valid"}, {31'b0, valid_out}, {31'b0, v});
        checkOutput({name, " instr"}, instr_out, ins);
        checkOutput({name, " pc"},    pc_out,    p4);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] ready_pattern;
        rst = 1'b1; branch_taken = 1'b0; branch_addr = '0; id_ready = 1'b1;

        // Reset holds everything empty and suppresses the fetch strobe.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkHead("reset", 1'b0, 32'h0, 32'h0);
        checkOutput("reset mem_read", {31'b0, mem_read}, 32'h0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);

        // Straight-line run with decode always ready.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("run first", 1'b1, 32'h0022_1000, 32'd4);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("run second", 1'b1, 32'h0064_1000, 32'd8);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("run seventh", 1'b1, 32'h01AE_1000, 32'd28);

        // Back-pressure: buffer fills, PC freezes, head stays put.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkHead("stall head", 1'b1, 32'h01AE_1000, 32'd28);
        checkOutput("stall mem_read", {31'b0, mem_read}, 32'h0);
        checkOutput("stall mem_addr", mem_addr, 32'd8);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("release", 1'b1, 32'h01F0_1000, 32'd32);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect to 0x10: bubble, then target instruction.
        applyStimulus(1'b0, 1'b1, 32'h10, 1'b1);
        checkHead("redirect bubble", 1'b0, 32'h0, 32'h0);
        checkOutput("redirect mem_addr", mem_addr, 32'd4);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("redirect target", 1'b1, 32'h012A_1000, 32'h14);

        // Fill to two entries, then redirect to unaligned 0x0B with a pop.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0B, 1'b1);
        checkHead("redirect pop", 1'b0, 32'h0, 32'h0);
        checkOutput("redirect pop mem_addr", mem_addr, 32'd2);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("redirect pop target", 1'b1, 32'h00A6_1000, 32'h0C);

        // Reset while full.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkHead("mid reset", 1'b0, 32'h0, 32'h0);
        checkOutput("mid reset mem_addr", mem_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("after reset", 1'b1, 32'h0022_1000, 32'd4);

        // Branch held for several cycles, then reset overriding a branch.
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h30, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h20, 1'b1);
        checkHead("held branch", 1'b0, 32'h0, 32'h0);
        checkOutput("held branch mem_addr", mem_addr, 32'd8);
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1);
        checkOutput("reset over branch mem_addr", mem_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Wrap-around at the top of the address space.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        checkOutput("wrap mem_addr", mem_addr, 32'h3FFF_FFFF);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("wrap head", 1'b1, 32'hFFE0_1000, 32'h0);
        checkOutput("wrap next mem_addr", mem_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkHead("wrap follow", 1'b1, 32'h0022_1000, 32'd4);

        // Irregular ready pattern, checked by the model only.
        ready_pattern = 16'b1011_0011_1000_1101;
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 32'h0, ready_pattern[i]);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the ARM pipeline. Holds the program counter and drives the word-indexed instruction memory's `addr`/`mem_read` port. Captures the combinational `read_data` into a 2-entry skid buffer and presents instructions to the decode stage with a valid/ready handshake. Branch redirects from downstream flush the buffer and reload the PC.

## Interface
- `INSTR_W`, 32: instruction and data width; equals `INSTRUCTION_LEN`.
- `ADDR_W`, 32: PC and memory address width.
- `RESET_PC`, 0: byte address loaded into the PC on reset; must be a multiple of 4.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `branch_taken`  in  1  one-cycle redirect request.
- `branch_addr`  in  ADDR_W  redirect byte address; bits [1:0] are ignored (treated as 0).
- `mem_addr`  out  ADDR_W  word index to the instruction memory, `{2'b0, pc[ADDR_W-1:2]}`.
- `mem_read`  out  1  fetch strobe to the memory.
- `mem_data`  in  INSTR_W  memory read data, valid in the same cycle as `mem_read`.
- `id_ready`  in  1  decode stage accepts the head instruction this cycle.
- `valid_out`  out  1  head-of-buffer entry is valid.
- `instr_out`  out  INSTR_W  head instruction; 0 when `valid_out`=0.
- `pc_out`  out  ADDR_W  byte address of the head instruction plus 4; 0 when `valid_out`=0.

## Operation
- State:
  - `pc` (byte address).
  - 2-entry FIFO of {instr, pc+4}.
  - `count` ∈ {0,1,2}.
  - Read/write pointers, 1 bit each.
- `pop` = `valid_out & id_ready`.
- `can_fetch` = (`count` < 2) | `pop`.
- `mem_read` = `!rst & !branch_taken & can_fetch`. This output is combinational.
- `mem_addr` always reflects the current `pc`, including when `mem_read`=0.
- Normal cycle (`mem_read`=1):
  - Push {`mem_data`, `pc`+4}.
  - `pc` <= `pc`+4.
- Stall (`can_fetch`=0, no branch): `pc` holds and nothing is pushed.
- Pop: head advances. Push and pop in the same cycle leaves `count` unchanged.
- Redirect (`branch_taken`=1):
  - `pc` <= {`branch_addr`[ADDR_W-1:2], 2'b00}.
  - `count` <= 0 and both pointers <= 0.
  - No fetch is issued.
  - The redirect overrides any simultaneous pop or push. The handshake that cycle is ignored, and an instruction shown that cycle is discarded even if `id_ready`=1.
- `branch_taken` held for several cycles: every cycle reloads the PC and keeps the buffer empty.
- PC arithmetic is modulo 2^ADDR_W. `pc`=0xFFFFFFFC wraps to 0, and the stored pc+4 is 0.
- FIFO full (`count`=2) with `id_ready`=0: nothing is fetched and the entries are kept unchanged and in order.
- FIFO empty: `valid_out`=0, and `id_ready` is don't-care.
- Reset (overrides everything, including a branch):
  - `pc` <= `RESET_PC`, `count` <= 0, pointers <= 0.
  - Outputs during and after reset, until the first push: `valid_out`=0, `instr_out`=0, `pc_out`=0, `mem_read`=0 while `rst`=1.
  - A reset mid-stall or mid-redirect discards all buffered entries.

## Timing
- Fetch at cycle t from PC A: the entry is visible at cycle t+1 with `instr_out`=mem[A>>2] and `pc_out`=A+4. Fetch latency is 1 cycle.
- First fetch occurs in the first cycle with `rst`=0. First `valid_out`=1 is one cycle later.
- Throughput is 1 instruction/cycle with `id_ready` held high. The buffer then sits at `count`=1 steady state.
- After `id_ready` deasserts:
  - The buffer fills to 2 within 1 cycle.
  - When `id_ready` rises again, output resumes the same cycle with no bubble and no lost or duplicated instruction.
- Redirect at cycle t: `valid_out`=0 at t+1. The first fetch from the target is at t+1, and the target instruction is valid at t+2. Redirect penalty is 2 cycles.
- `instr_out`/`pc_out`/`valid_out` are registered (from FIFO state). `mem_read` depends combinationally on `rst`, `branch_taken`, `id_ready` and state.

## Test plan
- Reset then run: memory preloaded with words 0..6 = 0x00221000, 0x00641000, …; `RESET_PC`=0; `id_ready`=1 -> `valid_out`=1 from cycle 2; `instr_out` sequence equals mem[0..6] in order; `pc_out`=4,8,…,28.
- Back-pressure: drop `id_ready` for 5 cycles mid-stream -> `mem_read` drops after 1 cycle; `count`=2; `pc` frozen; on release, instructions continue in order with none missing or duplicated.
- Redirect: `branch_taken`=1, `branch_addr`=0x10 at cycle t -> `valid_out`=0 at t+1; at t+2 `instr_out`=mem[4] and `pc_out`=0x14.
- Redirect with pop: `branch_taken`=1 and `id_ready`=1 with `count`=2 and `branch_addr`=0x0B -> both entries dropped; fetch resumes at 0x08; `mem_addr`=2.
- Reset mid-operation: assert `rst` one cycle while `count`=2 -> next cycle `valid_out`=0, `instr_out`=0, `pc_out`=0, `pc`=`RESET_PC`.
- Wrap-around: redirect to 0xFFFFFFFC -> `mem_addr`=0x3FFFFFFF, `pc_out`=0; next fetch has `mem_addr`=0.
